// File: rtl/controle_multiciclo.sv
// Multicycle control unit of the 8-bit processor: owns PC/IR, fetches over a
// req/ack handshake, decodes and sequences register-file/ALU control.
module controle_multiciclo #(
  parameter logic [7:0]  RESET_PC      = 8'h00,
  parameter int unsigned FETCH_TIMEOUT = 15
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       Start,
  output logic       Mem_req,
  output logic [7:0] Mem_addr,
  input  logic       Mem_ack,
  input  logic [7:0] Mem_data,
  input  logic       Zero,
  output logic       Reg_we,
  output logic [1:0] Reg_rd,
  output logic [1:0] Reg_rs,
  output logic       Alu_src_imm,
  output logic [7:0] Imm_ext,
  output logic [7:0] Pc,
  output logic       Halted,
  output logic       Erro,
  output logic [7:0] Instr_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT, S_ERRO
  } state_e;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_ADDI = 3'b010;
  localparam logic [2:0] OP_BEQZ = 3'b011;
  localparam logic [2:0] OP_JMP  = 3'b100;
  localparam logic [2:0] OP_HALT = 3'b111;

  // Last counter value before giving up: the FETCH_TIMEOUT-th request cycle.
  localparam logic [7:0] TMO_LAST = 8'(FETCH_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] tmo_q, tmo_d;
  logic [7:0] icnt_q, icnt_d;
  logic [2:0] op;
  logic [7:0] off8;
  logic [7:0] imm8;
  logic       retire;
  logic       in_instr;

  assign op   = ir_q[7:5];
  assign off8 = {{3{ir_q[4]}}, ir_q[4:0]};
  assign imm8 = {{6{ir_q[1]}}, ir_q[1:0]};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= 8'h00;
      tmo_q   <= 8'h00;
      icnt_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      tmo_q   <= tmo_d;
      icnt_q  <= icnt_d;
    end
  end

  // NOTE: every variable gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    tmo_d   = tmo_q;
    icnt_d  = icnt_q;
    retire  = 1'b0;

    case (state_q)
      S_IDLE, S_HALT, S_ERRO: begin
        if (Start) begin
          state_d = S_FETCH;
          pc_d    = RESET_PC;
          tmo_d   = 8'h00;
          icnt_d  = 8'h00;
        end
      end
      S_FETCH: begin
        if (Mem_ack) begin
          ir_d    = Mem_data;
          pc_d    = pc_q + 8'd1;
          tmo_d   = 8'h00;
          state_d = S_DECODE;
        end else if (tmo_q == TMO_LAST) begin
          tmo_d   = 8'h00;
          state_d = S_ERRO;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_DECODE: begin
        case (op)
          OP_NOP, OP_ADD, OP_ADDI, OP_BEQZ, OP_JMP: state_d = S_EXEC;
          OP_HALT: begin
            state_d = S_HALT;
            retire  = 1'b1;
          end
          default: state_d = S_ERRO;
        endcase
      end
      S_EXEC: begin
        if (op == OP_ADD || op == OP_ADDI) begin
          state_d = S_WB;
        end else begin
          state_d = S_FETCH;
          retire  = 1'b1;
          // Branch base is the already-incremented PC; wraps modulo 256.
          if (op == OP_JMP || (op == OP_BEQZ && Zero)) pc_d = pc_q + off8;
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (retire && icnt_q != 8'hFF) icnt_d = icnt_q + 8'd1;
  end

  assign in_instr    = (state_q == S_DECODE) || (state_q == S_EXEC) || (state_q == S_WB);
  assign Mem_req     = (state_q == S_FETCH);
  assign Mem_addr    = Mem_req ? pc_q : 8'h00;
  assign Reg_we      = (state_q == S_WB);
  assign Reg_rd      = in_instr ? ir_q[4:3] : 2'b00;
  assign Reg_rs      = in_instr ? ir_q[2:1] : 2'b00;
  assign Alu_src_imm = in_instr && (op == OP_ADDI);
  assign Imm_ext     = in_instr ? imm8 : 8'h00;
  assign Pc          = pc_q;
  assign Halted      = (state_q == S_HALT);
  assign Erro        = (state_q == S_ERRO);
  assign Instr_count = icnt_q;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Self-checking bench for controle_multiciclo: instruction-memory responder,
// write-back scoreboard and one task per scenario.
module tb_controle_multiciclo;

  logic       Clock = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Start = 1'b0;
  logic       Mem_req;
  logic [7:0] Mem_addr;
  logic       Mem_ack = 1'b0;
  logic [7:0] Mem_data = 8'h00;
  logic       Zero = 1'b0;
  logic       Reg_we;
  logic [1:0] Reg_rd;
  logic [1:0] Reg_rs;
  logic       Alu_src_imm;
  logic [7:0] Imm_ext;
  logic [7:0] Pc;
  logic       Halted;
  logic       Erro;
  logic [7:0] Instr_count;

  controle_multiciclo dut (
    .Clock(Clock), .Reset_n(Reset_n), .Start(Start),
    .Mem_req(Mem_req), .Mem_addr(Mem_addr), .Mem_ack(Mem_ack), .Mem_data(Mem_data),
    .Zero(Zero), .Reg_we(Reg_we), .Reg_rd(Reg_rd), .Reg_rs(Reg_rs),
    .Alu_src_imm(Alu_src_imm), .Imm_ext(Imm_ext), .Pc(Pc),
    .Halted(Halted), .Erro(Erro), .Instr_count(Instr_count)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [1:0] rd;
    logic [1:0] rs;
    logic       src_imm;
    logic [7:0] imm;
  } wb_t;

  int         total = 0;
  int         bad = 0;
  logic [7:0] mem [256];
  bit         ack_en = 1'b1;
  int         fetch_hits [256];
  int         fetch_total = 0;
  logic [7:0] last_fetch = 8'h00;
  wb_t        wb_q [$];
  wb_t        mon_exp;

  // Memory responder: acks in the same cycle the request is seen.
  always @(negedge Clock) begin
    if (ack_en && Mem_req) begin
      Mem_ack  = 1'b1;
      Mem_data = mem[Mem_addr];
      fetch_hits[Mem_addr] = fetch_hits[Mem_addr] + 1;
      fetch_total = fetch_total + 1;
      last_fetch  = Mem_addr;
    end else begin
      Mem_ack  = 1'b0;
      Mem_data = 8'h00;
    end
  end

  // Scoreboard: each Reg_we pulse pops one expected write-back.
  always @(negedge Clock) begin
    if (Reset_n && Reg_we) begin
      total++;
      if (wb_q.size() == 0) begin
        bad++;
        $display("FAIL wb_unexpected: got rd=%0d rs=%0d imm=%h, want no write-back", Reg_rd, Reg_rs, Imm_ext);
      end else begin
        mon_exp = wb_q.pop_front();
        if ({Reg_rd, Reg_rs, Alu_src_imm, Imm_ext} !== mon_exp) begin
          bad++;
          $display("FAIL wb_fields: got rd=%0d rs=%0d src=%0d imm=%h want rd=%0d rs=%0d src=%0d imm=%h",
                   Reg_rd, Reg_rs, Alu_src_imm, Imm_ext,
                   mon_exp.rd, mon_exp.rs, mon_exp.src_imm, mon_exp.imm);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic reset_dut(input logic [7:0] fill);
    Reset_n = 1'b0;
    Start   = 1'b0;
    Zero    = 1'b0;
    ack_en  = 1'b1;
    for (int i = 0; i < 256; i++) begin
      mem[i] = fill;
      fetch_hits[i] = 0;
    end
    fetch_total = 0;
    last_fetch  = 8'h00;
    wb_q.delete();
    repeat (2) @(negedge Clock);
    Reset_n = 1'b1;
    @(negedge Clock);
  endtask

  task automatic pulse_start();
    @(negedge Clock);
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
  endtask

  task automatic wait_cond(input bit sel_erro, input int max, output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    while (cyc < max) begin
      if (sel_erro ? Erro : Halted) begin
        ok = 1'b1;
        break;
      end
      @(negedge Clock);
      cyc++;
    end
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    #1;
    total++;
    if ({Mem_req, Reg_we, Alu_src_imm, Halted, Erro} !== 5'b0) begin
      bad++; $display("FAIL reset_flags: got %b want 00000", {Mem_req, Reg_we, Alu_src_imm, Halted, Erro});
    end
    total++;
    if ({Pc, Instr_count, Imm_ext, Reg_rd, Reg_rs} !== 28'h0) begin
      bad++; $display("FAIL reset_values: got pc=%h cnt=%h imm=%h rd=%0d rs=%0d want zeros", Pc, Instr_count, Imm_ext, Reg_rd, Reg_rs);
    end
    reset_dut(8'hE0);
    repeat (4) @(negedge Clock);
    total++;
    if ({Mem_req, Halted, Erro} !== 3'b0) begin
      bad++; $display("FAIL idle_without_start: got req/halt/erro=%b want 000", {Mem_req, Halted, Erro});
    end
  endtask

  task automatic test_addi_halt();
    int cyc; bit ok;
    reset_dut(8'hE0);
    mem[8'h00] = 8'h45;
    wb_q.push_back(wb_t'{rd: 2'd0, rs: 2'd2, src_imm: 1'b1, imm: 8'h01});
    pulse_start();
    wait_cond(1'b0, 50, cyc, ok);
    total++;
    if (!ok || cyc != 6) begin
      bad++; $display("FAIL addi_halt_latency: got ok=%0d cycles=%0d want ok=1 cycles=6", ok, cyc);
    end
    total++;
    if (Pc !== 8'h02 || Instr_count !== 8'd2) begin
      bad++; $display("FAIL addi_halt_state: got pc=%h cnt=%0d want pc=02 cnt=2", Pc, Instr_count);
    end
    total++;
    if (Mem_req !== 1'b0 || wb_q.size() != 0) begin
      bad++; $display("FAIL addi_halt_quiet: got req=%b pending_wb=%0d want 0 0", Mem_req, wb_q.size());
    end
  endtask

  task automatic test_imm_ext();
    int cyc; bit ok;
    reset_dut(8'hE0);
    mem[8'h00] = 8'h52;
    mem[8'h01] = 8'h5B;
    wb_q.push_back(wb_t'{rd: 2'd2, rs: 2'd1, src_imm: 1'b1, imm: 8'hFE});
    wb_q.push_back(wb_t'{rd: 2'd3, rs: 2'd1, src_imm: 1'b1, imm: 8'hFF});
    pulse_start();
    wait_cond(1'b0, 50, cyc, ok);
    total++;
    if (!ok || Pc !== 8'h03 || Instr_count !== 8'd3 || wb_q.size() != 0) begin
      bad++; $display("FAIL imm_ext_run: got ok=%0d pc=%h cnt=%0d pending_wb=%0d want 1 03 3 0", ok, Pc, Instr_count, wb_q.size());
    end
  endtask

  task automatic test_beqz(input bit z);
    int cyc; bit ok;
    logic [7:0] target;
    reset_dut(8'hE0);
    Zero = z;
    mem[8'h00] = 8'h84;
    mem[8'h05] = 8'h70;
    target = z ? 8'hF6 : 8'h06;
    pulse_start();
    wait_cond(1'b0, 50, cyc, ok);
    total++;
    if (!ok || last_fetch !== target || fetch_hits[5] != 1) begin
      bad++; $display("FAIL beqz_z%0d_target: got ok=%0d fetch=%h hits5=%0d want 1 %h 1", z, ok, last_fetch, fetch_hits[5], target);
    end
    total++;
    if (Pc !== target + 8'd1 || Instr_count !== 8'd3) begin
      bad++; $display("FAIL beqz_z%0d_pc: got pc=%h cnt=%0d want %h 3", z, Pc, Instr_count, target + 8'd1);
    end
  endtask

  task automatic test_jmp_wrap();
    int cyc; bit ok;
    reset_dut(8'hE0);
    mem[8'h00] = 8'h94;
    mem[8'hF5] = 8'h8F;
    pulse_start();
    wait_cond(1'b0, 50, cyc, ok);
    total++;
    if (!ok || fetch_hits[8'hF5] != 1 || last_fetch !== 8'h05 || Pc !== 8'h06) begin
      bad++; $display("FAIL jmp_wrap: got ok=%0d hitsF5=%0d fetch=%h pc=%h want 1 1 05 06", ok, fetch_hits[8'hF5], last_fetch, Pc);
    end
  endtask

  task automatic test_self_loop_saturate();
    reset_dut(8'hE0);
    mem[8'h00] = 8'h8F;
    mem[8'h10] = 8'h9F;
    pulse_start();
    repeat (800) @(negedge Clock);
    total++;
    if (Halted !== 1'b0 || Erro !== 1'b0 || fetch_total != 1 + fetch_hits[8'h10] || fetch_hits[8'h10] < 255) begin
      bad++; $display("FAIL self_loop: got halt=%b erro=%b total_fetch=%0d hits10=%0d want 0 0 1+hits hits>=255", Halted, Erro, fetch_total, fetch_hits[8'h10]);
    end
    total++;
    if (Instr_count !== 8'hFF) begin
      bad++; $display("FAIL count_saturate: got %0d want 255", Instr_count);
    end
  endtask

  task automatic test_timeout_and_undef();
    int cyc; bit ok;
    int req_cycles;
    reset_dut(8'hE0);
    ack_en = 1'b0;
    pulse_start();
    req_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (Erro) break;
      if (Mem_req) req_cycles++;
      @(negedge Clock);
    end
    total++;
    if (Erro !== 1'b1 || req_cycles != 15) begin
      bad++; $display("FAIL timeout: got erro=%b req_cycles=%0d want 1 15", Erro, req_cycles);
    end
    repeat (3) @(negedge Clock);
    total++;
    if (Mem_req !== 1'b0 || Erro !== 1'b1) begin
      bad++; $display("FAIL timeout_quiet: got req=%b erro=%b want 0 1", Mem_req, Erro);
    end
    ack_en = 1'b1;
    pulse_start();
    total++;
    if (Erro !== 1'b0 || Mem_req !== 1'b1 || Mem_addr !== 8'h00) begin
      bad++; $display("FAIL erro_restart: got erro=%b req=%b addr=%h want 0 1 00", Erro, Mem_req, Mem_addr);
    end
    wait_cond(1'b0, 20, cyc, ok);
    total++;
    if (!ok || Pc !== 8'h01) begin
      bad++; $display("FAIL erro_restart_halt: got ok=%0d pc=%h want 1 01", ok, Pc);
    end
    mem[8'h00] = 8'hA0;
    pulse_start();
    wait_cond(1'b1, 20, cyc, ok);
    total++;
    if (!ok || Instr_count !== 8'd0 || Pc !== 8'h01 || Halted !== 1'b0) begin
      bad++; $display("FAIL undef_op: got ok=%0d cnt=%0d pc=%h halt=%b want 1 0 01 0", ok, Instr_count, Pc, Halted);
    end
  endtask

  task automatic test_reset_mid_fetch();
    int n;
    reset_dut(8'h00);
    pulse_start();
    repeat (10) @(negedge Clock);
    n = 0;
    while (!Mem_req && n < 5) begin
      @(negedge Clock);
      n++;
    end
    total++;
    if (Mem_req !== 1'b1 || Instr_count == 8'd0 || Pc == 8'h00) begin
      bad++; $display("FAIL pre_reset_busy: got req=%b cnt=%0d pc=%h want 1 nonzero nonzero", Mem_req, Instr_count, Pc);
    end
    #2;
    Reset_n = 1'b0;
    #1;
    total++;
    if ({Mem_req, Reg_we} !== 2'b00 || Pc !== 8'h00 || Instr_count !== 8'h00) begin
      bad++; $display("FAIL async_reset: got req=%b we=%b pc=%h cnt=%0d want 0 0 00 0", Mem_req, Reg_we, Pc, Instr_count);
    end
    @(negedge Clock);
    Reset_n = 1'b1;
  endtask

  task automatic test_start_ignored();
    int cyc; bit ok;
    reset_dut(8'hE0);
    mem[8'h00] = 8'h45;
    wb_q.push_back(wb_t'{rd: 2'd0, rs: 2'd2, src_imm: 1'b1, imm: 8'h01});
    pulse_start();
    @(negedge Clock);
    Start = 1'b1;
    repeat (3) @(negedge Clock);
    Start = 1'b0;
    wait_cond(1'b0, 20, cyc, ok);
    total++;
    if (!ok || cyc != 2 || Pc !== 8'h02 || Instr_count !== 8'd2) begin
      bad++; $display("FAIL start_ignored: got ok=%0d cyc=%0d pc=%h cnt=%0d want 1 2 02 2", ok, cyc, Pc, Instr_count);
    end
    total++;
    if (fetch_hits[0] != 1 || fetch_hits[1] != 1 || wb_q.size() != 0) begin
      bad++; $display("FAIL start_ignored_fetch: got hits0=%0d hits1=%0d pending_wb=%0d want 1 1 0", fetch_hits[0], fetch_hits[1], wb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_addi_halt();
    test_imm_ext();
    test_beqz(1'b1);
    test_beqz(1'b0);
    test_jmp_wrap();
    test_self_loop_saturate();
    test_timeout_and_undef();
    test_reset_mid_fetch();
    test_start_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/controle_multiciclo.md
Name: controle_multiciclo

Overview:
- Multicycle control unit for the 8-bit processor.
- Owns PC and IR, and fetches instructions from instruction memory through a req/ack handshake.
- Decodes 8-bit instructions and sequences register-file/ALU control.
- Performs in-block sign extension of the 5-bit branch offset and the 2-bit immediate (two's complement, to 8 bits).
- Sits between instruction memory and the register/ALU datapath.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset and on Start.
- FETCH_TIMEOUT, 15, max cycles Mem_req may stay high without Mem_ack before entering ERRO (range 1..255).

Ports:
- Clock  input  1  system clock, rising edge
- Reset_n  input  1  asynchronous active-low reset
- Start  input  1  1-cycle pulse: leave IDLE/HALT/ERRO, PC<=RESET_PC, begin fetch
- Mem_req  output  1  instruction fetch request
- Mem_addr  output  8  fetch address (= PC while Mem_req=1)
- Mem_ack  input  1  fetch complete; Mem_data valid same cycle
- Mem_data  input  8  instruction word
- Zero  input  1  datapath zero flag (result of last ADD/ADDI)
- Reg_we  output  1  register-file write enable (1-cycle pulse)
- Reg_rd  output  2  destination/first-source register
- Reg_rs  output  2  second-source register
- Alu_src_imm  output  1  1: ALU B operand = Imm_ext; 0: register Reg_rs
- Imm_ext  output  8  sign-extended IR[1:0]
- Pc  output  8  current PC
- Halted  output  1  high in HALT
- Erro  output  1  high in ERRO
- Instr_count  output  8  retired instructions, saturates at 255

Behaviour:
- Reset (async, Reset_n=0):
  - State=IDLE, PC=RESET_PC, IR=0, timeout counter=0, Instr_count=0.
  - All 1-bit outputs 0; Reg_rd/Reg_rs/Imm_ext=0.
  - Reset mid-fetch drops Mem_req immediately.
- Instruction format: op=IR[7:5].
  - 000 NOP.
  - 001 ADD: rd=IR[4:3], rs=IR[2:1]; rd<=rd+rs.
  - 010 ADDI: rd=IR[4:3], rd<=rd+sext(IR[1:0]).
  - 011 BEQZ: if Zero, PC<=PC+sext(IR[4:0]).
  - 100 JMP: PC<=PC+sext(IR[4:0]).
  - 111 HALT.
  - 101, 110 undefined → ERRO.
- Sign extension:
  - off8={{3{IR[4]}},IR[4:0]}, range -16..+15.
  - imm8={{6{IR[1]}},IR[1:0]}, range -2..+1.
- PC arithmetic: modulo 256, wraps silently (8'hFF+1=8'h00; 8'h02+(-16)=8'hF2).
- Branch base: the already-incremented PC, i.e. address of instruction + 1.
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT, ERRO.
  - IDLE: all outputs idle. Start → FETCH with PC=RESET_PC.
  - FETCH:
    - Mem_req=1, Mem_addr=PC; the timeout counter increments each cycle without ack.
    - Mem_ack=1: IR<=Mem_data, PC<=PC+1, counter<=0 → DECODE.
    - Counter reaching FETCH_TIMEOUT without ack → ERRO; Mem_req drops the next cycle.
    - Ack arriving on the same cycle the counter hits the limit: ack wins.
  - DECODE (1 cycle):
    - Reg_rd/Reg_rs/Imm_ext/Alu_src_imm driven from IR.
    - Outputs stay stable from here through WB.
    - Undefined op → ERRO.
    - HALT → HALT.
    - Otherwise → EXEC.
  - EXEC (1 cycle):
    - ADD/ADDI → WB.
    - BEQZ samples Zero this cycle and updates PC if taken.
    - JMP updates PC.
    - NOP/BEQZ/JMP → FETCH.
  - WB (1 cycle): Reg_we=1 → FETCH.
  - HALT: Halted=1, no fetch. Start → FETCH from RESET_PC.
  - ERRO: Erro=1, no fetch. Start → FETCH from RESET_PC, Erro cleared.
- Start in FETCH/DECODE/EXEC/WB is ignored.
- Instr_count increments once per instruction on leaving EXEC or WB (HALT counts on entering HALT). It holds at 255 and is cleared by Start.
- Latency, assuming 1-cycle ack:
  - NOP/BEQZ/JMP: 3 cycles (FETCH, DECODE, EXEC).
  - ADD/ADDI: 4 cycles (FETCH, DECODE, EXEC, WB).

Test Plan:
- Reset, Start, memory: 0x00: 0x45 (ADDI r0,+1), 0x01: 0xE0 (HALT), ack 1 cycle after req → Reg_we pulse with Reg_rd=0, Imm_ext=8'h01, Alu_src_imm=1; Halted=1; Pc=8'h02; Instr_count=2.
- ADDI with imm=2'b10 (0x52) → Imm_ext=8'hFE; with imm=2'b11 → 8'hFF.
- BEQZ at 0x05 with offset 5'b10000 (0x70), Zero=1 → Pc=8'hF6. Same instruction with Zero=0 → Pc=8'h06, next Mem_addr=8'h06.
- JMP +15 at 0xF5 (0x8F) → Pc=8'h05 (wrap). JMP 5'b11111 at 0x10 → Pc=8'h10 (self-loop; repeated fetch of 0x10).
- Mem_ack never asserted, FETCH_TIMEOUT=15 → Erro=1 after 15 req cycles, Mem_req=0 afterwards. Start → refetch from 0x00, Erro=0. Undefined opcode 0xA0 → Erro=1.
- Reset_n pulled low while Mem_req=1 → Mem_req, Reg_we, Pc, Instr_count all 0 immediately, without waiting for a clock edge. Start ignored mid-instruction, and no PC change results.
